// File: rtl/color_thr_sched.sv
// color_thr_sched: per-pixel class scheduler, first class whose threshold the 3-channel sum strictly exceeds
// Ports: sys_clk/sys_rst_n (sync active-low); cfg_we/cfg_addr/cfg_thr threshold write port;
//        s_valid/s_ready/s_d1..s_d3 sample input; m_valid/m_ready/m_hit/m_idx result; busy = not idle
module color_thr_sched #(
  parameter int WIDTH = 16,
  parameter int NCLS  = 4,
  parameter int IDXW  = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_addr,
  input  logic [WIDTH-1:0] cfg_thr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_d1,
  input  logic [WIDTH-1:0] s_d2,
  input  logic [WIDTH-1:0] s_d3,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_hit,
  output logic [IDXW-1:0]  m_idx,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_thr [NCLS];
  logic [IDXW-1:0]  r_k, r_idx;
  logic [WIDTH+1:0] r_sum, w_sum;
  logic             r_cmp, r_hit, w_last;
  assign w_sum   = {2'b00, s_d1} + {2'b00, s_d2} + {2'b00, s_d3};
  assign w_last  = r_k == IDXW'(NCLS - 1);
  assign s_ready = r_state == IDLE;
  assign m_valid = r_state == DONE;
  assign busy    = r_state != IDLE;
  assign m_hit   = r_hit;
  assign m_idx   = r_idx;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = s_valid ? RUN : IDLE;
      RUN:     w_state_nxt = CHECK;
      CHECK:   w_state_nxt = (r_cmp || w_last) ? DONE : RUN;
      DONE:    w_state_nxt = m_ready ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_sum   <= '0;
      r_cmp   <= 1'b0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      for (int i = 0; i < NCLS; i++) r_thr[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (cfg_we && 32'(cfg_addr) < NCLS) r_thr[cfg_addr] <= cfg_thr;
      if (r_state == IDLE && s_valid) begin
        r_sum <= w_sum;
        r_k   <= '0;
      end
      // compare sees the threshold as registered before this edge, so a same-edge write only affects later samples
      if (r_state == RUN) r_cmp <= r_sum > {2'b00, r_thr[r_k]};
      if (r_state == CHECK) begin
        if (r_cmp) begin
          r_hit <= 1'b1;
          r_idx <= r_k;
        end else if (w_last) begin
          r_hit <= 1'b0;
          r_idx <= '0;
        end else begin
          r_k <= r_k + IDXW'(1);
        end
      end
    end
  end
endmodule
